// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

  // Word depth for a byte-address width.
  function automatic int unsigned imem_depth(input int unsigned addr_w);
    return 32'd1 << (addr_w - 32'd2);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one write port, one synchronous read port, no reset.
module imem_array #(
  parameter int unsigned AW = 7,
  parameter int unsigned W  = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data holds its last value whenever no read is issued.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_ld.sv
// Instruction memory with sequential program-load port and handshaked fetch port.
// Define IMEM_MISALIGN_CHECK_EN to flag fetches whose address is not word aligned.
module instr_mem_ld
  import imem_pkg::*;
#(
  parameter int unsigned INS_ADDRESS = 9,
  parameter int unsigned INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [INS_W-1:0]       ld_data,
  input  logic                   ld_last,
  output logic                   ld_busy,
  output logic [INS_ADDRESS-2:0] ld_count,
  input  logic                   req_valid,
  input  logic [INS_ADDRESS-1:0] req_addr,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [INS_W-1:0]       rsp_data,
  output logic                   rsp_err,
  input  logic                   rsp_ready
);

  localparam int unsigned WA    = INS_ADDRESS - 2;
  localparam int unsigned CW    = INS_ADDRESS - 1;
  localparam int unsigned DEPTH = imem_depth(INS_ADDRESS);

  imem_state_t    state_q, state_d;
  logic [WA-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           wr_en_c;
  logic           accept_c;
  logic [INS_W-1:0] rdata;

  // State, load pointer/counter and response-valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Load sequencing; ld_start always wins over a same-cycle ld_valid.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en_c = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (ld_start) begin
          state_d = LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (ld_start) begin
          ptr_d = '0;
          cnt_d = '0;
        end else if (ld_valid) begin
          wr_en_c = 1'b1;
          ptr_d   = ptr_q + WA'(1);
          cnt_d   = cnt_q + CW'(1);
          // Filling the last word ends the load; the pointer never wraps into live code.
          if (ld_last || (ptr_q == WA'(DEPTH - 1))) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Fetch handshake: a held response blocks new accepts until consumed.
  always_comb begin
    req_ready   = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
    accept_c    = req_valid && req_ready;
    rsp_valid_d = accept_c || (rsp_valid_q && !rsp_ready);
  end

  imem_array #(
    .AW (WA),
    .W  (INS_W)
  ) u_array (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (ptr_q),
    .wdata (ld_data),
    .re    (accept_c),
    .raddr (req_addr[INS_ADDRESS-1:2]),
    .rdata (rdata)
  );

`ifdef IMEM_MISALIGN_CHECK_EN
  logic rsp_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (accept_c) begin
      rsp_err_q <= (req_addr[1:0] != 2'b00);
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_byte_offset;

  assign unused_byte_offset = ^req_addr[1:0];
  assign rsp_err            = 1'b0;
`endif

  // Storage is not reset, so data is masked to zero whenever no response is held.
  assign rsp_data  = rsp_valid_q ? rdata : '0;
  assign rsp_valid = rsp_valid_q;
  assign ld_busy   = (state_q == LOAD);
  assign ld_count  = cnt_q;

endmodule

// File: tb/tb_instr_mem_ld.sv
// Randomized self-checking bench for instr_mem_ld against a word-array reference model.
module tb_instr_mem_ld;

  localparam int unsigned AW    = 9;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_start, ld_valid, ld_last;
  logic [W-1:0]  ld_data;
  logic          ld_busy;
  logic [AW-2:0] ld_count;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid, rsp_err, rsp_ready;
  logic [W-1:0]  rsp_data;

  instr_mem_ld #(.INS_ADDRESS(AW), .INS_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_busy   (ld_busy),
    .ld_count  (ld_count),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  // Reference model: memory image plus the architectural view of load/fetch status.
  logic [W-1:0] ref_mem [DEPTH];
  bit           known   [DEPTH];
  logic [W-1:0] img     [DEPTH];
  bit           m_run, m_loading, m_pend, m_err, m_known;
  logic [W-1:0] m_data;
  int           m_cnt;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_err(input logic [AW-1:0] a);
`ifdef IMEM_MISALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0 & a[0];
`endif
  endfunction

  // One clock: check outputs at negedge, advance the fetch model at posedge.
  task automatic cyc();
    bit rdy, acc;
    @(negedge clk);
    rdy = m_run && (!m_pend || rsp_ready);
    chk("req_ready", 64'(req_ready), 64'(rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_pend));
    if (m_pend) begin
      if (m_known) chk("rsp_data", 64'(rsp_data), 64'(m_data));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
    chk("ld_busy", 64'(ld_busy), 64'(m_loading));
    chk("ld_count", 64'(ld_count), 64'(m_cnt));
    acc = req_valid && rdy;
    @(posedge clk);
    if (acc) begin
      m_pend  = 1'b1;
      m_data  = ref_mem[req_addr[AW-1:2]];
      m_known = known[req_addr[AW-1:2]];
      m_err   = exp_err(req_addr);
    end else if (rsp_ready) begin
      m_pend = 1'b0;
    end
    #1;
  endtask

  // Load img[0..n-1]; the start cycle carries a junk ld_valid that must be ignored.
  task automatic load_image(input int n, input bit use_last, input bit finish, input bit gaps);
    ld_start = 1'b1; ld_valid = 1'b1; ld_last = 1'b0; ld_data = $urandom;
    req_valid = 1'($urandom); req_addr = AW'($urandom); rsp_ready = 1'($urandom);
    cyc();
    ld_start = 1'b0; m_loading = 1'b1; m_run = 1'b0; m_cnt = 0;
    for (int i = 0; i < n; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0; ld_last = 1'($urandom); ld_data = $urandom;
        req_valid = 1'($urandom); rsp_ready = 1'($urandom);
        cyc();
      end
      ld_valid = 1'b1; ld_data = img[i];
      ld_last = finish && use_last && (i == n - 1);
      req_valid = 1'($urandom); rsp_ready = 1'($urandom);
      cyc();
      ref_mem[i] = img[i]; known[i] = 1'b1; m_cnt++;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    if (finish) begin m_loading = 1'b0; m_run = 1'b1; end
  endtask

  task automatic fetch(input logic [AW-1:0] a, input bit rdy);
    req_valid = 1'b1; req_addr = a; rsp_ready = rdy;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin ref_mem[i] = '0; known[i] = 1'b0; img[i] = '0; end
    m_run = 0; m_loading = 0; m_pend = 0; m_err = 0; m_known = 0; m_data = '0; m_cnt = 0;
    reset = 1'b1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    req_valid = 1'b1; req_addr = '0; rsp_ready = 1'b1;

    // Reset values with a pending request
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_ld_busy", 64'(ld_busy), 64'(0));
    chk("rst_ld_count", 64'(ld_count), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) cyc();

    // Small image with ld_last, then back-to-back fetches
    img[0] = 32'h0000_0013; img[1] = 32'h0010_0093; img[2] = 32'h0020_0113; img[3] = 32'h0030_0193;
    load_image(4, 1'b1, 1'b1, 1'b0);
    req_valid = 1'b0; rsp_ready = 1'b1; cyc();
    chk("cnt4", 64'(ld_count), 64'(4));
    for (int i = 0; i < 4; i++) fetch(AW'(i * 4), 1'b1);
    req_valid = 1'b0; cyc();

    // Back-pressure: response held three cycles, accept on release
    fetch(AW'(4), 1'b1);
    for (int i = 0; i < 3; i++) fetch(AW'(8), 1'b0);
    chk("held_data", 64'(rsp_data), 64'(32'h0010_0093));
    fetch(AW'(8), 1'b1);
    req_valid = 1'b0; cyc(); cyc();

    // Full image without ld_last ends at the last word
    for (int i = 0; i < int'(DEPTH); i++) img[i] = $urandom;
    load_image(int'(DEPTH), 1'b0, 1'b1, 1'b0);
    req_valid = 1'b0; rsp_ready = 1'b1; cyc();
    chk("cnt128", 64'(ld_count), 64'(DEPTH));
    fetch(AW'(9'h1FC), 1'b1);
    fetch(AW'(9'h006), 1'b1);
    req_valid = 1'b0; cyc();

    // Restart mid-load with a same-cycle ld_valid
    for (int i = 0; i < 5; i++) img[i] = $urandom;
    load_image(5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) img[i] = $urandom;
    load_image(2, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) fetch(AW'(i * 4), 1'b1);
    req_valid = 1'b0; cyc();

    // Random loads interleaved with random fetch traffic
    for (int r = 0; r < 4; r++) begin
      int n;
      bit lst;
      n = $urandom_range(1, int'(DEPTH));
      lst = (n < int'(DEPTH)) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < n; i++) img[i] = $urandom;
      load_image(n, lst, 1'b1, 1'b1);
      for (int c = 0; c < 250; c++) begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_addr  = AW'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
        cyc();
      end
    end

    // Reset during a pending fetch drops the response at once
    fetch(AW'(12), 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_mid_req_ready", 64'(req_ready), 64'(0));
    chk("rst_mid_ld_busy", 64'(ld_busy), 64'(0));
    chk("rst_mid_ld_count", 64'(ld_count), 64'(0));
    m_pend = 0; m_run = 0; m_loading = 0; m_cnt = 0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1; cyc();

    // Contents survive reset and a one-word reload
    img[0] = $urandom;
    load_image(1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) fetch(AW'(i * 4), ($urandom_range(0, 3) != 0));
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_ld.md
# instr_mem_ld

Parametrised instruction memory with a sequential program-load port and a registered, handshaked fetch port. It replaces the combinational instruction ROM between the PC/fetch stage and the decoder. Software or a boot loader streams words in after reset. The core then fetches with a one-cycle read latency and back-pressure.

## Interface
- INS_ADDRESS, 9, byte-address width of the fetch address; depth = 2**(INS_ADDRESS-2) words
- INS_W, 32, instruction word width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- ld_start  in  1  pulse: begin a new load at word 0
- ld_valid  in  1  ld_data valid this cycle
- ld_data  in  INS_W  word to write
- ld_last  in  1  qualifies ld_valid: final word of the image
- ld_busy  out  1  high while in LOAD
- ld_count  out  INS_ADDRESS-1  number of words written in current/last load (0..depth)
- req_valid  in  1  fetch request valid
- req_addr  in  INS_ADDRESS  byte address of instruction
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  response valid
- rsp_data  out  INS_W  fetched instruction
- rsp_err  out  1  misaligned request (see Configuration)
- rsp_ready  in  1  consumer accepts response

## Operation
- FSM states: IDLE (no image), LOAD, RUN. Reset enters IDLE.
- IDLE or RUN, ld_start=1: go to LOAD, ld_count<=0, write pointer<=0.
- LOAD, ld_start=1: restart, pointer<=0, ld_count<=0. A same-cycle ld_valid is ignored because ld_start has priority.
- LOAD, ld_valid=1: mem[pointer]<=ld_data, pointer++, ld_count++.
- LOAD, ld_valid && ld_last: the word is written, then go to RUN.
- LOAD, write to word depth-1 without ld_last: the word is written, go to RUN, ld_count=depth. No wrap to 0.
- ld_last without ld_valid is ignored.
- req_ready = (state==RUN) && (!rsp_valid || rsp_ready).
- Accepted request: rsp_data<=mem[req_addr[INS_ADDRESS-1:2]], rsp_err per Configuration, rsp_valid<=1.
- rsp_valid && !rsp_ready: rsp_data and rsp_err are held stable and no new request is accepted.
- rsp_ready && no new accept: rsp_valid<=0.
- Leaving RUN for LOAD while a response is pending: the held response stays valid until consumed. No new accepts occur in LOAD.
- Memory contents are not reset. Contents persist across reset and across a partial reload above ld_count.

## Timing
- Reset values: ld_busy=0, ld_count=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- Read latency is 1 cycle, from the accept edge to rsp_valid.
- Full throughput is 1 fetch per cycle while rsp_ready=1.
- Load throughput is 1 word per cycle.
- The first fetch can be accepted in the cycle after the edge that enters RUN.
- A write and a read of the same word can never coincide, because fetch is blocked in LOAD.
- Reset asserted mid-load or mid-fetch forces IDLE immediately. Any pending response is dropped.

## Configuration
- IMEM_MISALIGN_CHECK_EN defined: rsp_err = (req_addr[1:0] != 0), captured at accept. rsp_data is still the word at the truncated index.
- IMEM_MISALIGN_CHECK_EN not defined: rsp_err is constant 0 and req_addr[1:0] is ignored.

## Structure
- Package imem_pkg holds:
  - enum imem_state_t {IDLE, LOAD, RUN}
  - function imem_depth(addr_w) returning 2**(addr_w-2)
- Sub-module imem_array holds storage only: one write port (we, waddr, wdata) and one synchronous read port (re, raddr, rdata). rdata holds when re=0. No reset.
- The top holds the FSM, load pointer/counter and the response register/handshake.

## Test plan
- Reset, then req_valid=1 -> req_ready=0 and rsp_valid=0 (IDLE). All outputs equal their reset values.
- ld_start, then 4 words 0x00000013, 0x00100093, 0x00200113, 0x00300193 with ld_last on the 4th -> ld_count=4, RUN. Fetches of 0x000, 0x004, 0x008, 0x00C back-to-back return those words, one per cycle, each 1 cycle after accept.
- Issue a fetch of 0x004 with rsp_ready=0 for 3 cycles -> rsp_data=0x00100093 held, req_ready=0. On release, the next request is accepted in the same cycle.
- Load 128 words without ld_last -> RUN after the 128th, ld_count=128. Fetch 0x1FC returns the last word.
- With IMEM_MISALIGN_CHECK_EN, fetch 0x006 -> rsp_err=1 and rsp_data=mem[1]. Without the macro, rsp_err=0.
- Assert ld_start mid-load together with ld_valid -> pointer and ld_count return to 0 and that word is not written. Assert reset mid-fetch -> rsp_valid=0 immediately and state is IDLE.
